// File: rtl/branch_resolve_if.sv
// Branch-resolve bundle: issue/flag inputs toward the resolver and the
// redirect/status outputs coming back from it.
interface branch_resolve_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             new_jmp;
    logic [2:0]       jmp_type;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  jalr_base;
    logic             flag_valid;
    logic [3:0]       alu_csr;
    logic [XLEN-1:0]  newPC;
    logic             ctrlFetch;
    logic             global_reset;
    logic [CNT_W-1:0] pending;
    logic             full;
    logic             err;

    modport master (
        output new_jmp, jmp_type, imm, pc, jalr_base, flag_valid, alu_csr,
        input  newPC, ctrlFetch, global_reset, pending, full, err
    );

    modport slave (
        input  new_jmp, jmp_type, imm, pc, jalr_base, flag_valid, alu_csr,
        output newPC, ctrlFetch, global_reset, pending, full, err
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolver: queues conditional branches in issue order, resolves the
// oldest one when compare flags arrive, and redirects fetch (with a flush)
// for taken branches and unconditional jumps one cycle after the trigger.
module branch_resolve #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int PC_SKEW = 8
) (
    input logic              clock,
    input logic              reset,
    branch_resolve_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    localparam logic [2:0] F_BEQ  = 3'b000;
    localparam logic [2:0] F_BNE  = 3'b001;
    localparam logic [2:0] F_JAL  = 3'b010;
    localparam logic [2:0] F_JALR = 3'b011;
    localparam logic [2:0] F_BLT  = 3'b100;
    localparam logic [2:0] F_BGE  = 3'b101;
    localparam logic [2:0] F_BLTU = 3'b110;
    localparam logic [2:0] F_BGEU = 3'b111;

    // Branch condition from {negative, overflow, carry(borrow), zero} of rs1-rs2.
    function automatic logic cond_eval(input logic [2:0] funct3, input logic [3:0] csr);
        logic n, v, c, z, r;
        n = csr[3];
        v = csr[2];
        c = csr[1];
        z = csr[0];
        case (funct3)
            F_BEQ:   r = z;
            F_BNE:   r = ~z;
            F_BLT:   r = n ^ v;
            F_BGE:   r = ~(n ^ v);
            F_BLTU:  r = c;
            F_BGEU:  r = ~c;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // The supplied pc runs PC_SKEW ahead of the branch instruction itself.
    function automatic logic [XLEN-1:0] rel_target(input logic [XLEN-1:0] pc_v,
                                                   input logic [XLEN-1:0] imm_v);
        return pc_v + imm_v - XLEN'(PC_SKEW);
    endfunction

    logic [2:0]      type_mem [DEPTH];
    logic [XLEN-1:0] tgt_mem  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [XLEN-1:0]  newpc_q, newpc_d;
    logic             ctrl_fetch_q, gbl_reset_q, redirect_d;
    logic             err_q, err_d;

    logic             wr_en_s;
    logic [XLEN-1:0]  wr_tgt_s;
    logic             empty_s, is_full_s, pop_s, taken_s;
    logic             is_jal_s, is_jalr_s, is_cond_s, push_s;
    logic [2:0]       head_type_s;
    logic [XLEN-1:0]  head_tgt_s;

    assign head_type_s = type_mem[head_q];
    assign head_tgt_s  = tgt_mem[head_q];
    assign empty_s     = (cnt_q == '0);
    assign is_full_s   = (cnt_q == DEPTH_C);
    assign pop_s       = bus.flag_valid & ~empty_s;
    assign taken_s     = pop_s & cond_eval(head_type_s, bus.alu_csr);
    assign is_jal_s    = bus.new_jmp & (bus.jmp_type == F_JAL);
    assign is_jalr_s   = bus.new_jmp & (bus.jmp_type == F_JALR);
    assign is_cond_s   = bus.new_jmp & ~is_jal_s & ~is_jalr_s;
    assign wr_tgt_s    = rel_target(bus.pc, bus.imm);

    // Next-state: a taken head wins over everything and flushes the queue;
    // otherwise handle jump redirects, pop, and push independently.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        newpc_d    = newpc_q;
        redirect_d = 1'b0;
        err_d      = err_q;
        wr_en_s    = 1'b0;
        push_s     = 1'b0;

        if (taken_s) begin
            redirect_d = 1'b1;
            newpc_d    = head_tgt_s;
            head_d     = '0;
            tail_d     = '0;
            cnt_d      = '0;
        end else begin
            if (is_jal_s) begin
                redirect_d = 1'b1;
                newpc_d    = wr_tgt_s;
            end else if (is_jalr_s) begin
                redirect_d = 1'b1;
                newpc_d    = (bus.jalr_base + bus.imm) & ~XLEN'(1);
            end else begin
                redirect_d = 1'b0;
            end

            // A pop in the same cycle frees the slot, so a full queue still accepts.
            if (is_cond_s && (!is_full_s || pop_s)) begin
                push_s  = 1'b1;
                wr_en_s = 1'b1;
                tail_d  = tail_q + PTR_ONE;
            end else if (is_cond_s) begin
                err_d = 1'b1;
            end else begin
                push_s = 1'b0;
            end

            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end

            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end

        if (bus.flag_valid && empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end

        full_d = (cnt_d == DEPTH_C);
    end

    // State and registered outputs; reset clears everything and overrides inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            newpc_q      <= '0;
            ctrl_fetch_q <= 1'b0;
            gbl_reset_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            newpc_q      <= newpc_d;
            ctrl_fetch_q <= redirect_d;
            gbl_reset_q  <= redirect_d;
            err_q        <= err_d;
        end
    end

    // Queue storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            type_mem[tail_q] <= bus.jmp_type;
            tgt_mem[tail_q]  <= wr_tgt_s;
        end
    end

    assign bus.newPC        = newpc_q;
    assign bus.ctrlFetch    = ctrl_fetch_q;
    assign bus.global_reset = gbl_reset_q;
    assign bus.pending      = cnt_q;
    assign bus.full         = full_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    branch_resolve_if #(.XLEN(32), .DEPTH(4)) bus ();

    branch_resolve #(.XLEN(32), .DEPTH(4), .PC_SKEW(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.new_jmp    = 1'b0;
        bus.jmp_type   = 3'b000;
        bus.imm        = 32'h0;
        bus.pc         = 32'h0;
        bus.jalr_base  = 32'h0;
        bus.flag_valid = 1'b0;
        bus.alu_csr    = 4'b0000;
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] b);
        bus.new_jmp   = 1'b1;
        bus.jmp_type  = t;
        bus.pc        = p;
        bus.imm       = i;
        bus.jalr_base = b;
    endtask

    task automatic flags(input logic [3:0] c);
        bus.flag_valid = 1'b1;
        bus.alu_csr    = c;
    endtask

    task automatic redirect_chk(input string tag, input logic [31:0] tgt);
        check_eq({tag, "_ctrl"}, bus.ctrlFetch, 1'b1);
        check_eq({tag, "_grst"}, bus.global_reset, 1'b1);
        check_eq({tag, "_pc"}, bus.newPC, tgt);
    endtask

    logic [2:0] fill_types [4];
    logic [3:0] nt_flags   [4];

    initial begin
        checks   = 0;
        failures = 0;
        fill_types[0] = 3'b000; nt_flags[0] = 4'b0000; // BEQ, Z=0
        fill_types[1] = 3'b001; nt_flags[1] = 4'b0001; // BNE, Z=1
        fill_types[2] = 3'b110; nt_flags[2] = 4'b0000; // BLTU, C=0
        fill_types[3] = 3'b111; nt_flags[3] = 4'b0010; // BGEU, C=1

        // Reset state
        idle();
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_newpc", bus.newPC, 32'h0);
        check_eq("rst_ctrl", bus.ctrlFetch, 1'b0);
        check_eq("rst_grst", bus.global_reset, 1'b0);
        check_eq("rst_pend", bus.pending, 3'd0);
        check_eq("rst_full", bus.full, 1'b0);
        check_eq("rst_err", bus.err, 1'b0);
        reset = 1'b0;

        // BEQ taken: 0x100 + 0x20 - 8 = 0x118
        issue(3'b000, 32'h100, 32'h20, 32'h0);
        tick();
        idle();
        check_eq("beq_pend1", bus.pending, 3'd1);
        check_eq("beq_noctrl", bus.ctrlFetch, 1'b0);
        tick();
        flags(4'b0001);
        tick();
        idle();
        redirect_chk("beq", 32'h118);
        check_eq("beq_pend0", bus.pending, 3'd0);
        tick();
        check_eq("beq_oneshot", bus.ctrlFetch, 1'b0);
        check_eq("beq_hold", bus.newPC, 32'h118);

        // BLT taken: 0x200 - 0x10 - 8 = 0x1E8
        issue(3'b100, 32'h200, 32'hFFFF_FFF0, 32'h0);
        tick();
        flags(4'b0100);
        bus.new_jmp = 1'b0;
        tick();
        idle();
        redirect_chk("blt_t", 32'h1E8);
        // BLT not taken (N=1, V=1)
        issue(3'b100, 32'h200, 32'hFFFF_FFF0, 32'h0);
        tick();
        idle();
        check_eq("blt_nt_pend1", bus.pending, 3'd1);
        flags(4'b1100);
        tick();
        idle();
        check_eq("blt_nt_ctrl", bus.ctrlFetch, 1'b0);
        check_eq("blt_nt_pend0", bus.pending, 3'd0);
        check_eq("blt_nt_pc", bus.newPC, 32'h1E8);
        check_eq("err_clean", bus.err, 1'b0);

        // Fill queue (wraps the pointers), overflow, then drain in order
        for (int i = 0; i < 4; i++) begin
            issue(fill_types[i], 32'h1000 + 32'(i) * 32'h10, 32'h0, 32'h0);
            tick();
        end
        idle();
        check_eq("fill_pend", bus.pending, 3'd4);
        check_eq("fill_full", bus.full, 1'b1);
        check_eq("fill_noerr", bus.err, 1'b0);
        issue(3'b000, 32'h1400, 32'h0, 32'h0);
        tick();
        idle();
        check_eq("ovf_pend", bus.pending, 3'd4);
        check_eq("ovf_err", bus.err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            flags(nt_flags[i]);
            tick();
            idle();
            check_eq($sformatf("drain%0d_pend", i), bus.pending, 3'(3 - i));
            check_eq($sformatf("drain%0d_ctrl", i), bus.ctrlFetch, 1'b0);
        end
        check_eq("drain_full", bus.full, 1'b0);
        check_eq("err_sticky", bus.err, 1'b1);

        // JALR with two pending: (0x1001 + 0x10) & ~1 = 0x1010
        issue(3'b000, 32'h300, 32'h0, 32'h0);
        tick();
        issue(3'b000, 32'h400, 32'h0, 32'h0);
        tick();
        issue(3'b011, 32'h0, 32'h10, 32'h1001);
        tick();
        idle();
        redirect_chk("jalr", 32'h1010);
        check_eq("jalr_pend", bus.pending, 3'd2);
        tick();
        check_eq("jalr_oneshot", bus.ctrlFetch, 1'b0);
        // JAL: 0x500 + 0x40 - 8 = 0x538
        issue(3'b010, 32'h500, 32'h40, 32'h0);
        tick();
        idle();
        redirect_chk("jal", 32'h538);
        check_eq("jal_pend", bus.pending, 3'd2);

        // Taken head with same-cycle BNE issue: redirect to 0x2F8, BNE squashed
        flags(4'b0001);
        issue(3'b001, 32'h600, 32'h0, 32'h0);
        tick();
        idle();
        redirect_chk("squash", 32'h2F8);
        check_eq("squash_pend", bus.pending, 3'd0);
        tick();
        check_eq("squash_pend2", bus.pending, 3'd0);

        // Push + non-taken pop while full, then taken pop reveals second entry
        for (int i = 0; i < 4; i++) begin
            issue(3'b000, 32'h700 + 32'(i) * 32'h10, 32'h0, 32'h0);
            tick();
        end
        idle();
        flags(4'b0000);
        issue(3'b000, 32'h800, 32'h0, 32'h0);
        tick();
        idle();
        check_eq("pp_pend", bus.pending, 3'd4);
        check_eq("pp_full", bus.full, 1'b1);
        check_eq("pp_ctrl", bus.ctrlFetch, 1'b0);
        flags(4'b0001);
        tick();
        idle();
        redirect_chk("pp_taken", 32'h708);
        check_eq("pp_taken_pend", bus.pending, 3'd0);

        // Non-taken pop with same-cycle JAL: 0xA00 + 8 - 8 = 0xA00
        issue(3'b001, 32'h900, 32'h0, 32'h0);
        tick();
        idle();
        flags(4'b0001);
        issue(3'b010, 32'hA00, 32'h8, 32'h0);
        tick();
        idle();
        redirect_chk("ntjal", 32'hA00);
        check_eq("ntjal_pend", bus.pending, 3'd0);

        // Reset with three pending and a taken flag present
        for (int i = 0; i < 3; i++) begin
            issue(3'b000, 32'hB00 + 32'(i) * 32'h10, 32'h0, 32'h0);
            tick();
        end
        idle();
        check_eq("pre_rst_pend", bus.pending, 3'd3);
        flags(4'b0001);
        reset = 1'b1;
        tick();
        check_eq("mrst_newpc", bus.newPC, 32'h0);
        check_eq("mrst_ctrl", bus.ctrlFetch, 1'b0);
        check_eq("mrst_grst", bus.global_reset, 1'b0);
        check_eq("mrst_pend", bus.pending, 3'd0);
        check_eq("mrst_full", bus.full, 1'b0);
        check_eq("mrst_err", bus.err, 1'b0);
        reset = 1'b0;
        idle();
        tick();
        check_eq("post_rst_ctrl", bus.ctrlFetch, 1'b0);
        check_eq("post_rst_pend", bus.pending, 3'd0);

        // Flags with empty queue: ignored, error raised and held
        flags(4'b0001);
        tick();
        idle();
        check_eq("empty_err", bus.err, 1'b1);
        check_eq("empty_ctrl", bus.ctrlFetch, 1'b0);
        check_eq("empty_pend", bus.pending, 3'd0);
        tick();
        check_eq("empty_err_hold", bus.err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
